// File: rtl/xoodyak_seq.sv
// Sequencer for a single-shot Xoodyak encryption in front of an external one-round Xoodoo datapath.
// Runs four 12-round permutations, injecting nonce, AD, plaintext/domain bytes, and emits ciphertext and tag.
module xoodyak_seq #(
  parameter int NROUNDS = 12,
  parameter int SW      = 384
) (
  input  logic          eph1,
  input  logic          reset,
  input  logic          start,
  input  logic [127:0]  key,
  input  logic [127:0]  nonce,
  input  logic [127:0]  ad,
  input  logic [191:0]  plaintext,
  output logic [SW-1:0] rnd_in,
  output logic [31:0]   rnd_const,
  input  logic [SW-1:0] rnd_out,
  output logic          busy,
  output logic          done,
  output logic [191:0]  ciphertext,
  output logic [127:0]  authtag
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_PERM   = 1'b1;
  localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);

  logic [SW-1:0] r_state;
  logic [3:0]    r_rnd_cnt;
  logic [1:0]    r_phase;
  logic [0:0]    r_fsm;
  logic          r_done;
  logic [191:0]  r_ct;
  logic [127:0]  r_tag;
  logic [127:0]  r_nonce;
  logic [127:0]  r_ad;
  logic [191:0]  r_pt;

  logic          w_accept;
  logic          w_last;
  logic [191:0]  w_ct;
  logic [SW-1:0] w_inj;

  assign w_accept   = start && (r_fsm == S_IDLE);
  assign w_last     = (r_rnd_cnt == LAST_RND);
  assign busy       = (r_fsm == S_PERM);
  assign done       = r_done;
  assign ciphertext = r_ct;
  assign authtag    = r_tag;
  assign rnd_in     = r_state;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    rnd_const = 32'h0;
    case (r_rnd_cnt)
      4'd0:    rnd_const = 32'h058;
      4'd1:    rnd_const = 32'h038;
      4'd2:    rnd_const = 32'h3C0;
      4'd3:    rnd_const = 32'h0D0;
      4'd4:    rnd_const = 32'h120;
      4'd5:    rnd_const = 32'h014;
      4'd6:    rnd_const = 32'h060;
      4'd7:    rnd_const = 32'h02C;
      4'd8:    rnd_const = 32'h380;
      4'd9:    rnd_const = 32'h0F0;
      4'd10:   rnd_const = 32'h1A0;
      4'd11:   rnd_const = 32'h012;
      default: rnd_const = 32'h0;
    endcase
  end

  // Injection applied on the last round of each permutation, fused into the same edge.
  always_comb begin
    w_ct  = rnd_out[383:192] ^ r_pt;
    w_inj = rnd_out;
    case (r_phase)
      2'd0:    w_inj = rnd_out ^ {r_nonce, 8'h01, 248'h0};
      2'd1:    w_inj = rnd_out ^ {r_ad, 8'h01, 240'h0, 8'h80};
      2'd2:    w_inj = {w_ct, rnd_out[191:184] ^ 8'h01, rnd_out[183:8], rnd_out[7:0] ^ 8'h40};
      default: w_inj = rnd_out;
    endcase
  end

  always_ff @(posedge eph1) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      r_state   <= '0;
      r_rnd_cnt <= 4'd0;
      r_phase   <= 2'd0;
      r_fsm     <= S_IDLE;
      r_done    <= 1'b0;
      r_ct      <= '0;
      r_tag     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state   <= {key, 8'h01, 240'h0, 8'h02};
        r_rnd_cnt <= 4'd0;
        r_phase   <= 2'd0;
        r_fsm     <= S_PERM;
        r_ct      <= '0;
        r_tag     <= '0;
      end else if (r_fsm == S_PERM) begin
        if (!w_last) begin
          r_state   <= rnd_out;
          r_rnd_cnt <= r_rnd_cnt + 4'd1;
        end else begin
          r_state   <= w_inj;
          r_rnd_cnt <= 4'd0;
          r_phase   <= r_phase + 2'd1;
          if (r_phase == 2'd2) begin
            r_ct <= w_ct;
          end
          if (r_phase == 2'd3) begin
            r_tag  <= rnd_out[383:256];
            r_fsm  <= S_IDLE;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the input latches carry no reset; they are only read after an accept has loaded them.
  always_ff @(posedge eph1) begin
    if (!reset && w_accept) begin
      r_nonce <= nonce;
      r_ad    <= ad;
      r_pt    <= plaintext;
    end
  end

  a_cnt_range: assert property (@(posedge eph1) disable iff (reset)
    (r_fsm == S_PERM) |-> (r_rnd_cnt <= LAST_RND));

  a_done_idle: assert property (@(posedge eph1) disable iff (reset)
    r_done |-> (r_fsm == S_IDLE));

endmodule

// File: tb/tb_xoodyak_seq.sv
// Scoreboarded bench for xoodyak_seq: a behavioural Xoodoo round closes the datapath loop,
// a whole-message golden model fills the scoreboard, and a negedge monitor checks timing and results.
module tb_xoodyak_seq;

  logic         eph1;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic [127:0] nonce;
  logic [127:0] ad;
  logic [191:0] plaintext;
  logic [383:0] rnd_in;
  logic [31:0]  rnd_const;
  logic [383:0] rnd_out;
  logic         busy;
  logic         done;
  logic [191:0] ciphertext;
  logic [127:0] authtag;

  xoodyak_seq dut (
    .eph1       (eph1),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .nonce      (nonce),
    .ad         (ad),
    .plaintext  (plaintext),
    .rnd_in     (rnd_in),
    .rnd_const  (rnd_const),
    .rnd_out    (rnd_out),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext),
    .authtag    (authtag)
  );

  localparam logic [31:0]  RC_T [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                         32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};
  localparam logic [191:0] MASK      = {8'hFF, 176'h0, 8'h01};
  localparam int           LAT       = 48;

  typedef struct {
    logic [191:0] ct;
    logic [127:0] tag;
    int           acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_prev = -1000;
  int   acc_cur  = -1000;
  bit   in_reset = 1'b1;

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;
  always @(posedge eph1) cyc <= cyc + 1;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // One Xoodoo round on a 3x4 grid of 32-bit lanes, lane (y,x) at bits [32*(4y+x) +: 32].
  function automatic logic [383:0] xround(input logic [383:0] s, input logic [31:0] rc);
    logic [31:0] a [3][4];
    logic [31:0] b [3][4];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [31:0] t [4];
    logic [383:0] o;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
    for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
    t = a[1];
    for (int x = 0; x < 4; x++) begin
      a[1][x] = t[(x+3)%4];
      a[2][x] = rotl(a[2][x], 11);
    end
    a[0][0] = a[0][0] ^ rc;
    for (int x = 0; x < 4; x++) begin
      b[0][x] = ~a[1][x] & a[2][x];
      b[1][x] = ~a[2][x] & a[0][x];
      b[2][x] = ~a[0][x] & a[1][x];
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ b[y][x];
    t = a[2];
    for (int x = 0; x < 4; x++) begin
      a[1][x] = rotl(a[1][x], 1);
      a[2][x] = rotl(t[(x+2)%4], 8);
    end
    o = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) o[32*(4*y+x) +: 32] = a[y][x];
    return o;
  endfunction

  always_comb rnd_out = xround(rnd_in, rnd_const);

  function automatic logic [383:0] perm(input logic [383:0] s);
    logic [383:0] v;
    v = s;
    for (int r = 0; r < 12; r++) v = xround(v, RC_T[r]);
    return v;
  endfunction

  task automatic golden(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a,
                        input logic [191:0] p, output logic [191:0] ct, output logic [127:0] tg);
    logic [383:0] s;
    s  = perm({k, 8'h01, 240'h0, 8'h02});
    s  = perm(s ^ {n, 8'h01, 248'h0});
    s  = perm(s ^ {a, 8'h01, 240'h0, 8'h80});
    ct = s[383:192] ^ p;
    s  = perm({ct, s[191:184] ^ 8'h01, s[183:8], s[7:0] ^ 8'h40});
    tg = s[383:256];
  endtask

  function automatic bit in_win(input int c, input int a);
    return (c >= a) && (c < a + LAT);
  endfunction

  function automatic bit model_busy(input int c);
    return in_win(c, acc_prev) || in_win(c, acc_cur);
  endfunction

  function automatic bit model_done(input int c);
    return (c == acc_prev + LAT) || (c == acc_cur + LAT);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [191:0] rand192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  // Drives one start pulse; the bench's own timing model decides whether it will be accepted.
  task automatic issue_start(input logic [127:0] k, input logic [127:0] n, input logic [127:0] a,
                             input logic [191:0] p);
    logic [191:0] ct;
    logic [127:0] tg;
    key       = k;
    nonce     = n;
    ad        = a;
    plaintext = p;
    start     = 1'b1;
    if (!model_busy(cyc)) begin
      golden(k, n, a, p, ct, tg);
      sb_q.push_back('{ct, tg, cyc + 1});
      acc_prev = acc_cur;
      acc_cur  = cyc + 1;
    end
    tick();
    start     = 1'b0;
    key       = rand128();
    nonce     = rand128();
    ad        = rand128();
    plaintext = rand192();
  endtask

  task automatic run_to_done();
    for (int g = 0; g < 200 && cyc < acc_cur + LAT; g++) tick();
    check("done_cycle_reached", 384'(cyc), 384'(acc_cur + LAT));
  endtask

  always @(negedge eph1) begin
    if (!in_reset) begin
      check("busy", 384'(busy), 384'(model_busy(cyc)));
      check("done", 384'(done), 384'(model_done(cyc)));
      if (model_busy(cyc))
        check("rnd_const", 384'(rnd_const),
              384'(RC_T[(cyc - (in_win(cyc, acc_cur) ? acc_cur : acc_prev)) % 12]));
      if (cyc == acc_cur) begin
        check("ct_cleared_on_accept", 384'(ciphertext), 384'(0));
        check("tag_cleared_on_accept", 384'(authtag), 384'(0));
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 384'(1), 384'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check("ciphertext", 384'(ciphertext), 384'(mon_e.ct));
          check("authtag", 384'(authtag), 384'(mon_e.tag));
          check("latency", 384'(cyc - mon_e.acc), 384'(LAT));
        end
      end
    end
  end

  logic [127:0] lk, ln, la;
  logic [191:0] lp, ct1;
  logic [127:0] tg1;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    key       = '0;
    nonce     = '0;
    ad        = '0;
    plaintext = '0;
    tick();
    tick();
    reset    = 1'b0;
    in_reset = 1'b0;
    check("rst_busy", 384'(busy), 384'(0));
    check("rst_done", 384'(done), 384'(0));
    check("rst_ct", 384'(ciphertext), 384'(0));
    check("rst_tag", 384'(authtag), 384'(0));
    check("rst_rnd_in", rnd_in, 384'(0));
    check("rst_rnd_const", 384'(rnd_const), 384'(32'h058));
    tick();
    tick();

    // All-zero run with an ignored start at cycle 10 of the operation.
    issue_start('0, '0, '0, '0);
    while (cyc < acc_cur + 10) tick();
    issue_start(rand128(), rand128(), rand128(), rand192());
    run_to_done();

    // Eight operations, each started in the previous done cycle.
    for (int i = 0; i < 8; i++) begin
      issue_start(rand128(), rand128(), rand128(), rand192());
      run_to_done();
    end
    repeat (5) tick();

    // Plaintext linearity: same key/nonce/ad, plaintexts differing by MASK.
    lk = rand128();
    ln = rand128();
    la = rand128();
    lp = rand192();
    issue_start(lk, ln, la, lp);
    run_to_done();
    ct1 = ciphertext;
    tg1 = authtag;
    issue_start(lk, ln, la, lp ^ MASK);
    run_to_done();
    check("ct_linearity", 384'(ct1 ^ ciphertext), 384'(MASK));
    check("tag_differs", 384'(tg1 != authtag), 384'(1));
    repeat (3) tick();

    // Reset in the middle of an operation abandons it without a done pulse.
    issue_start(rand128(), rand128(), rand128(), rand192());
    while (cyc < acc_cur + 20) tick();
    in_reset = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    acc_prev = -1000;
    acc_cur  = -1000;
    sb_q.delete();
    in_reset = 1'b0;
    check("midrst_busy", 384'(busy), 384'(0));
    check("midrst_done", 384'(done), 384'(0));
    check("midrst_ct", 384'(ciphertext), 384'(0));
    check("midrst_tag", 384'(authtag), 384'(0));
    check("midrst_rnd_in", rnd_in, 384'(0));
    repeat (100) tick();

    issue_start(rand128(), rand128(), rand128(), rand192());
    run_to_done();
    repeat (3) tick();

    check("scoreboard_drained", 384'(sb_q.size()), 384'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
